ram_port_arbiter: RTL and testbench
===================================

Name: ram_port_arbiter

Overview:
- Shares the single-port 16x8 program/data RAM between three requesters:
  - 0: instruction fetch (PC/MAR path).
  - 1: data access (LDA/LDB loads, accumulator stores).
  - 2: external loader/debug port.
- Sits between the requesters and the RAM array. Grants one access at a time, sequences the memory control signals, and returns read data with a per-requester valid strobe.

Parameters:
- AW, 4, address width (16 locations).
- DW, 8, data width.
- FIXED_PRIO, 0, arbitration policy: 0 = round-robin; 1 = fixed priority 0 > 1 > 2.
- LOCK_MAX, 8, maximum consecutive locked grants to requester 2 before a forced release.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  3  per-requester access request; bit i = requester i.
- we  in  3  per-requester write enable (1 = write, 0 = read); valid with req.
- addr  in  3*AW  per-requester address; requester i at [i*AW +: AW].
- wdata  in  3*DW  per-requester write data; requester i at [i*DW +: DW].
- lock  in  1  requester 2 requests back-to-back ownership.
- gnt  out  3  one-hot, registered; high for the single ACCESS cycle of the winner.
- rvalid  out  3  one-hot, registered; high for one cycle when read data is returned to requester i.
- rdata  out  DW  read data, shared by all requesters, qualified by rvalid.
- mem_addr  out  AW  RAM address.
- mem_we  out  1  RAM write strobe.
- mem_wdata  out  DW  RAM write data.
- mem_rdata  in  DW  RAM read data; synchronous, valid the cycle after the address is presented.
- busy  out  1  high whenever the state is not IDLE.

Behaviour:
- Reset: state = IDLE; gnt, rvalid, mem_we, busy = 0; mem_addr, mem_wdata, rdata = 0; rr_ptr = 2 (requester 0 wins first); lock_cnt = 0. Reset mid-transaction aborts immediately: no write strobe, no rvalid.
- States:
  - IDLE: if any req bit is set, latch the winner's index, we, addr and wdata, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS (1 cycle):
    - Assert gnt[win]; drive mem_addr from the latch; drive mem_we = latched we and mem_wdata.
    - Read: go to RESP.
    - Write: go to IDLE.
  - RESP (1 cycle): rvalid[win] = 1 and rdata = mem_rdata; go to IDLE.
- Latency: read = 3 cycles from the IDLE sampling edge to rvalid; write = 2 cycles (RAM updated at the end of ACCESS).
- Throughput: at most one access in flight.
- Latching: the request is latched at the IDLE edge. Changes to req/addr/wdata after latching are ignored, and the access completes even if req drops.
- Requester contract: hold req and operands stable until gnt; deassert or change them the cycle after gnt.
- Round-robin (FIXED_PRIO=0):
  - Search order is rr_ptr+1, rr_ptr+2, rr_ptr+3, modulo 3.
  - rr_ptr is updated to the winner on entering ACCESS.
  - Arithmetic is modulo 3, with explicit wrap 2 -> 0.
- Fixed priority (FIXED_PRIO=1): the lowest requesting index wins; rr_ptr is unused.
- Lock:
  - If the last winner was 2, lock=1, req[2]=1 and lock_cnt < LOCK_MAX-1, requester 2 wins regardless of policy and lock_cnt increments.
  - Otherwise normal arbitration applies and lock_cnt clears.
  - lock_cnt reaching LOCK_MAX-1 forces one normal arbitration; after that arbitration, lock may re-engage only if requester 2 wins normally.
- Simultaneous events: a req arriving in ACCESS or RESP is considered only at the next IDLE edge. There is no bypass from RESP straight to ACCESS.
- Outputs outside ACCESS: mem_we = 0; mem_addr and mem_wdata hold their last values.

Test Plan:
- Single read:
  - Stimulus: reset, then req=001, we=000, addr0=4'h6, RAM[6]=8'h0E.
  - Response: gnt=001 in cycle 2, mem_addr=6, rvalid=001 with rdata=8'h0E in cycle 3, busy low in cycle 4.
- Write then read-back:
  - Stimulus: req=010, we=010, addr1=4'hF, wdata1=8'hA5; then a read of F by requester 0.
  - Response: mem_we pulses once with addr F / data A5; the read returns rvalid=001 with rdata=A5.
- Round-robin fairness:
  - Stimulus: req=111 held for 9 accesses, all reads.
  - Response: grant order 0,1,2,0,1,2,0,1,2; each rvalid follows its gnt by one cycle.
- Fixed priority:
  - Stimulus: FIXED_PRIO=1, req=110 held.
  - Response: every grant goes to 1; requester 2 is starved.
- Lock limit:
  - Stimulus: LOCK_MAX=4, req=101, lock=1.
  - Response: one round-robin grant to 0 first (rr_ptr=2 after reset), then grants 2,2,2,2,0,2,...; requester 0 is served after at most 4 consecutive locked grants to 2.
- Reset mid-read:
  - Stimulus: reset asserted in ACCESS of a read.
  - Response: no rvalid, busy=0 the next cycle, rr_ptr=2, and the next req=111 grants requester 0.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - three-way arbiter and access sequencer for the shared 16x8 RAM
// Latches one winner per IDLE edge, drives the RAM for one ACCESS cycle, returns reads in RESP.
module ram_port_arbiter #(
    parameter int AW         = 4,
    parameter int DW         = 8,
    parameter int FIXED_PRIO = 0,
    parameter int LOCK_MAX   = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      req,
    input  logic [2:0]      we,
    input  logic [3*AW-1:0] addr,
    input  logic [3*DW-1:0] wdata,
    input  logic            lock,
    output logic [2:0]      gnt,
    output logic [2:0]      rvalid,
    output logic [DW-1:0]   rdata,
    output logic [AW-1:0]   mem_addr,
    output logic            mem_we,
    output logic [DW-1:0]   mem_wdata,
    input  logic [DW-1:0]   mem_rdata,
    output logic            busy
);

    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [CW-1:0] LOCK_LIM = CW'(LOCK_MAX - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t          state_q, state_d;
    logic [1:0]      win_q, win_d;
    logic            we_q, we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic            mem_we_q, mem_we_d;
    logic [2:0]      gnt_q, gnt_d;
    logic [2:0]      rvalid_q, rvalid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [1:0]      rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
    logic            last2_q, last2_d;

    logic [1:0]      c1, c2, c3, nrm_win, sel;
    logic            lock_take;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_wdata;

    function automatic logic [1:0] nxt(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        c1 = nxt(rr_ptr_q);
        c2 = nxt(c1);
        c3 = nxt(c2);
        nrm_win = 2'd2;
        if (FIXED_PRIO != 0) begin
            if (req[0])      nrm_win = 2'd0;
            else if (req[1]) nrm_win = 2'd1;
            else             nrm_win = 2'd2;
        end else begin
            if (req[c1])      nrm_win = c1;
            else if (req[c2]) nrm_win = c2;
            else              nrm_win = c3;
        end
        // Lock holds requester 2 only while it keeps winning; the cap forces one normal round.
        lock_take = last2_q && lock && req[2] && (lock_cnt_q < LOCK_LIM);
        sel = lock_take ? 2'd2 : nrm_win;
        case (sel)
            2'd0:    begin sel_addr = addr[0 +: AW];    sel_wdata = wdata[0 +: DW];    end
            2'd1:    begin sel_addr = addr[AW +: AW];   sel_wdata = wdata[DW +: DW];   end
            default: begin sel_addr = addr[2*AW +: AW]; sel_wdata = wdata[2*DW +: DW]; end
        endcase
    end

    always_comb begin
        state_d     = state_q;
        win_d       = win_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_we_d    = 1'b0;
        gnt_d       = 3'b000;
        rvalid_d    = 3'b000;
        rdata_d     = rdata_q;
        rr_ptr_d    = rr_ptr_q;
        lock_cnt_d  = lock_cnt_q;
        last2_d     = last2_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d     = ACCESS;
                    win_d       = sel;
                    we_d        = we[sel];
                    mem_addr_d  = sel_addr;
                    mem_wdata_d = sel_wdata;
                    mem_we_d    = we[sel];
                    gnt_d[sel]  = 1'b1;
                    rr_ptr_d    = sel;
                    lock_cnt_d  = lock_take ? lock_cnt_q + 1'b1 : '0;
                    last2_d     = (sel == 2'd2);
                end
            end
            ACCESS: begin
                if (we_q) begin
                    state_d = IDLE;
                end else begin
                    state_d         = RESP;
                    rvalid_d[win_q] = 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
                rdata_d = mem_rdata;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            win_q       <= 2'd0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            gnt_q       <= 3'b000;
            rvalid_q    <= 3'b000;
            rdata_q     <= '0;
            rr_ptr_q    <= 2'd2;
            lock_cnt_q  <= '0;
            last2_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            win_q       <= win_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            gnt_q       <= gnt_d;
            rvalid_q    <= rvalid_d;
            rdata_q     <= rdata_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_cnt_q  <= lock_cnt_d;
            last2_q     <= last2_d;
        end
    end

    // The RAM answers during RESP, so read data is passed straight through and then held.
    assign rdata     = (state_q == RESP) ? mem_rdata : rdata_q;
    assign gnt       = gnt_q;
    assign rvalid    = rvalid_q;
    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - scoreboard bench for ram_port_arbiter
module tb_ram_port_arbiter;
    localparam int AW = 4;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset;
    logic [2:0]      req, we;
    logic [3*AW-1:0] addr;
    logic [3*DW-1:0] wdata;
    logic            lock;
    logic [2:0]      gnt, rvalid;
    logic [DW-1:0]   rdata, mem_wdata, mem_rdata;
    logic [AW-1:0]   mem_addr;
    logic            mem_we, busy;

    logic [2:0]      req_f, we_f, gnt_f, rvalid_f;
    logic [3*AW-1:0] addr_f;
    logic [3*DW-1:0] wdata_f;
    logic            lock_f, mem_we_f, busy_f;
    logic [DW-1:0]   rdata_f, mem_wdata_f, mem_rdata_f;
    logic [AW-1:0]   mem_addr_f;

    logic            ld_en;
    logic [AW-1:0]   ld_addr;
    logic [DW-1:0]   ld_data;
    logic [DW-1:0]   ram_m [16];
    logic [DW-1:0]   ram_f [16];

    ram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(0), .LOCK_MAX(4)) u_dut (
        .clk(clk), .reset(reset), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .lock(lock), .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
    );

    ram_port_arbiter #(.AW(AW), .DW(DW), .FIXED_PRIO(1), .LOCK_MAX(8)) u_fp (
        .clk(clk), .reset(reset), .req(req_f), .we(we_f), .addr(addr_f), .wdata(wdata_f),
        .lock(lock_f), .gnt(gnt_f), .rvalid(rvalid_f), .rdata(rdata_f), .mem_addr(mem_addr_f),
        .mem_we(mem_we_f), .mem_wdata(mem_wdata_f), .mem_rdata(mem_rdata_f), .busy(busy_f)
    );

    always @(posedge clk) begin
        if (ld_en) begin
            ram_m[ld_addr] <= ld_data;
            ram_f[ld_addr] <= ld_data;
        end else begin
            if (mem_we)   ram_m[mem_addr]   <= mem_wdata;
            if (mem_we_f) ram_f[mem_addr_f] <= mem_wdata_f;
        end
        mem_rdata   <= ram_m[mem_addr];
        mem_rdata_f <= ram_f[mem_addr_f];
    end

    typedef struct {
        logic [2:0]    g;
        logic [AW-1:0] a;
        logic          w;
        logic [DW-1:0] d;
    } gexp_t;
    typedef struct {
        logic [2:0]    v;
        logic [DW-1:0] d;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    int checks = 0;
    int errors = 0;
    int we_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_g(input logic [2:0] g, input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
        gexp_t e;
        e.g = g; e.a = a; e.w = w; e.d = d;
        gq.push_back(e);
    endtask

    task automatic push_r(input logic [2:0] v, input logic [DW-1:0] d);
        rexp_t e;
        e.v = v; e.d = d;
        rq.push_back(e);
    endtask

    initial begin : monitor
        gexp_t ge;
        rexp_t re;
        logic [2:0] prev_rd;
        prev_rd = 3'b000;
        forever begin
            @(negedge clk);
            if (reset) begin
                prev_rd = 3'b000;
            end else begin
                if (gnt !== 3'b000) begin
                    if (gq.size() == 0) begin
                        chk("unexpected_gnt", 32'(gnt), 32'd0);
                    end else begin
                        ge = gq.pop_front();
                        chk("gnt", 32'(gnt), 32'(ge.g));
                        chk("mem_addr", 32'(mem_addr), 32'(ge.a));
                        chk("mem_we", 32'(mem_we), 32'(ge.w));
                        if (ge.w) chk("mem_wdata", 32'(mem_wdata), 32'(ge.d));
                    end
                end
                if (rvalid !== 3'b000) begin
                    chk("rvalid_follows_gnt", 32'(rvalid), 32'(prev_rd));
                    if (rq.size() == 0) begin
                        chk("unexpected_rvalid", 32'(rvalid), 32'd0);
                    end else begin
                        re = rq.pop_front();
                        chk("rvalid", 32'(rvalid), 32'(re.v));
                        chk("rdata", 32'(rdata), 32'(re.d));
                    end
                end
                if (mem_we) begin
                    we_pulses++;
                    chk("mem_we_only_in_access", 32'(|gnt), 32'd1);
                end
                prev_rd = (gnt !== 3'b000 && !mem_we) ? gnt : 3'b000;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_gnts(input int n, input string name);
        int seen = 0;
        int cyc = 0;
        while (seen < n && cyc < 300) begin
            tick();
            cyc++;
            if (gnt !== 3'b000) seen++;
        end
        if (seen < n) chk({name, "_timeout"}, 32'(seen), 32'(n));
    endtask

    task automatic wait_idle(input string name);
        int cyc = 0;
        while (busy !== 1'b0 && cyc < 50) begin
            tick();
            cyc++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic apply_reset();
        chk("scoreboard_drained", 32'(gq.size() + rq.size()), 32'd0);
        gq.delete();
        rq.delete();
        reset = 1'b1;
        req = 3'b000;
        lock = 1'b0;
        req_f = 3'b000;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [DW-1:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en = 1'b1;
        tick();
        ld_en = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        logic [DW-1:0] rrd [3];
        int ord [11];
        int p0, nf, idx;
        rrd = '{8'h11, 8'h22, 8'h33};
        ord = '{0, 2, 2, 2, 2, 0, 2, 2, 2, 2, 0};

        reset = 1'b1; req = 3'b000; we = 3'b000; addr = '0; wdata = '0; lock = 1'b0;
        req_f = 3'b000; we_f = 3'b000; addr_f = '0; wdata_f = '0; lock_f = 1'b0;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        repeat (2) tick();
        load(4'h6, 8'h0E);
        load(4'h1, 8'h11);
        load(4'h2, 8'h22);
        load(4'h3, 8'h33);

        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_rvalid", 32'(rvalid), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        reset = 1'b0;
        tick();

        // single read with cycle-exact latency
        addr[0 +: AW] = 4'h6;
        push_g(3'b001, 4'h6, 1'b0, 8'h00);
        push_r(3'b001, 8'h0E);
        req = 3'b001;
        tick();
        chk("t1_gnt_cycle2", 32'(gnt), 32'b001);
        req = 3'b000;
        tick();
        chk("t1_rvalid_cycle3", 32'(rvalid), 32'b001);
        chk("t1_rdata_cycle3", 32'(rdata), 32'h0E);
        tick();
        chk("t1_busy_cycle4", 32'(busy), 32'd0);

        // write F/A5 from requester 1, then read it back through requester 0
        addr[AW +: AW] = 4'hF;
        wdata[DW +: DW] = 8'hA5;
        we = 3'b010;
        p0 = we_pulses;
        push_g(3'b010, 4'hF, 1'b1, 8'hA5);
        req = 3'b010;
        wait_gnts(1, "t2_write");
        req = 3'b000;
        we = 3'b000;
        wait_idle("t2_write_idle");
        chk("t2_we_pulses", 32'(we_pulses - p0), 32'd1);
        addr[0 +: AW] = 4'hF;
        push_g(3'b001, 4'hF, 1'b0, 8'h00);
        push_r(3'b001, 8'hA5);
        req = 3'b001;
        wait_gnts(1, "t2_read");
        req = 3'b000;
        wait_idle("t2_read_idle");

        // round-robin fairness
        apply_reset();
        addr = {4'h3, 4'h2, 4'h1};
        we = 3'b000;
        for (int k = 0; k < 9; k++) begin
            idx = k % 3;
            push_g(3'(1 << idx), 4'(idx + 1), 1'b0, 8'h00);
            push_r(3'(1 << idx), rrd[idx]);
        end
        req = 3'b111;
        wait_gnts(9, "t3_rr");
        req = 3'b000;
        wait_idle("t3_rr_idle");

        // lock limit with LOCK_MAX=4
        apply_reset();
        lock = 1'b1;
        for (int k = 0; k < 11; k++) begin
            push_g(3'(1 << ord[k]), 4'(ord[k] + 1), 1'b0, 8'h00);
            push_r(3'(1 << ord[k]), rrd[ord[k]]);
        end
        req = 3'b101;
        wait_gnts(11, "t4_lock");
        req = 3'b000;
        lock = 1'b0;
        wait_idle("t4_lock_idle");

        // reset during ACCESS of a read
        apply_reset();
        addr[0 +: AW] = 4'h5;
        push_g(3'b001, 4'h5, 1'b0, 8'h00);
        req = 3'b001;
        wait_gnts(1, "t5_read");
        @(negedge clk);
        #1;
        reset = 1'b1;
        req = 3'b000;
        @(posedge clk);
        #1;
        chk("t5_rvalid_after_reset", 32'(rvalid), 32'd0);
        chk("t5_busy_after_reset", 32'(busy), 32'd0);
        reset = 1'b0;
        addr[0 +: AW] = 4'h1;
        push_g(3'b001, 4'h1, 1'b0, 8'h00);
        push_r(3'b001, 8'h11);
        req = 3'b111;
        wait_gnts(1, "t5_regrant");
        req = 3'b000;
        wait_idle("t5_idle");

        // fixed priority instance: requester 1 always beats 2
        apply_reset();
        addr_f = {4'h3, 4'h2, 4'h1};
        req_f = 3'b110;
        nf = 0;
        for (int k = 0; k < 18; k++) begin
            tick();
            if (gnt_f !== 3'b000) begin
                nf++;
                chk("fp_gnt", 32'(gnt_f), 32'b010);
            end
            if (rvalid_f !== 3'b000) begin
                chk("fp_rvalid", 32'(rvalid_f), 32'b010);
                chk("fp_rdata", 32'(rdata_f), 32'h22);
            end
        end
        req_f = 3'b000;
        chk("fp_grant_count", 32'(nf), 32'd6);
        repeat (4) tick();
        chk("final_scoreboard_drained", 32'(gq.size() + rq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
